// File: rtl/decode_stage_pkg.sv
// Shared opcode, ALU-op, branch-type and write-back encodings for the decode stage.
package decode_stage_pkg;

  // RV32I major opcodes recognised by the decoder (full 7-bit field, low bits 11).
  typedef enum logic [6:0] {
    R_TYPE = 7'b0110011,
    I_TYPE = 7'b0010011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111
  } opcode_e;

  // ALU op is {funct3, instr[30]} for R/I types. PASS uses a code no
  // legal R/I instruction produces, so it cannot collide with them.
  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] PASS = 4'b1111;

  // Branch types: BRANCH forwards funct3. PC and ALU use funct3 values
  // (010, 011) that no conditional branch encodes.
  localparam logic [2:0] PC  = 3'b010;
  localparam logic [2:0] ALU = 3'b011;

  // Write-back source select.
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Purely combinational RV32I instruction decoder feeding the decode pipeline register.
module decode_logic
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic [2:0]      br_type,
  output logic [2:0]      rd_wr_mem,
  output logic [1:0]      wb_sel,
  output logic            reg_wr,
  output logic            mem_wr,
  output logic            sel_a,
  output logic            sel_b,
  output logic            illegal,
  output logic            rs1_used,
  output logic            rs2_used
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        writes_rd;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign rd        = instr[11:7];
  assign rd_wr_mem = funct3;

  // The five RV32I immediate formats, each sign-extended to 32 bits.
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign imm = XLEN'($signed(imm32));

  // Opcode decode: defaults describe a generic legal non-R instruction; unknown opcodes fall to default.
  always_comb begin
    alu_op    = ADD;
    br_type   = PC;
    wb_sel    = WB_ALU;
    mem_wr    = 1'b0;
    sel_a     = 1'b0;
    sel_b     = 1'b1;
    illegal   = 1'b0;
    imm32     = '0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      R_TYPE: begin
        alu_op    = {funct3, instr[30]};
        sel_b     = 1'b0;
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
      end
      I_TYPE: begin
        alu_op    = {funct3, (funct3 == 3'b101) ? instr[30] : 1'b0};
        imm32     = imm_i;
        writes_rd = 1'b1;
      end
      LOAD: begin
        imm32     = imm_i;
        wb_sel    = WB_MEM;
        writes_rd = 1'b1;
      end
      STORE: begin
        imm32    = imm_s;
        mem_wr   = 1'b1;
        rs2_used = 1'b1;
      end
      BRANCH: begin
        imm32    = imm_b;
        br_type  = funct3;
        sel_a    = 1'b1;
        rs2_used = 1'b1;
      end
      LUI: begin
        imm32     = imm_u;
        alu_op    = PASS;
        sel_a     = 1'b1;
        rs1_used  = 1'b0;
        writes_rd = 1'b1;
      end
      AUIPC: begin
        imm32     = imm_u;
        sel_a     = 1'b1;
        rs1_used  = 1'b0;
        writes_rd = 1'b1;
      end
      JAL: begin
        imm32     = imm_j;
        br_type   = ALU;
        wb_sel    = WB_PC4;
        sel_a     = 1'b1;
        rs1_used  = 1'b0;
        writes_rd = 1'b1;
      end
      JALR: begin
        imm32     = imm_i;
        br_type   = ALU;
        wb_sel    = WB_PC4;
        writes_rd = 1'b1;
      end
      default: begin
        illegal  = 1'b1;
        sel_b    = 1'b0;
        rs1_used = 1'b0;
      end
    endcase
    reg_wr = writes_rd && (rd != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: load-use hazard detection, registered decode slot and fetch-stall counter.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  input  logic             ex_ready,
  input  logic             flush,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic [XLEN-1:0]  id_imm,
  output logic [3:0]       id_alu_op,
  output logic [2:0]       id_br_type,
  output logic [2:0]       id_rd_wr_mem,
  output logic [1:0]       id_wb_sel,
  output logic             id_reg_wr,
  output logic             id_mem_wr,
  output logic             id_sel_A,
  output logic             id_sel_B,
  output logic             id_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu_op;
  logic [2:0]      dec_br_type;
  logic [2:0]      dec_rd_wr_mem;
  logic [1:0]      dec_wb_sel;
  logic            dec_reg_wr;
  logic            dec_mem_wr;
  logic            dec_sel_a;
  logic            dec_sel_b;
  logic            dec_illegal;
  logic            dec_rs1_used;
  logic            dec_rs2_used;
  logic            hazard;
  logic            advance;

  decode_logic #(.XLEN(XLEN)) u_decode (
    .instr     (if_instr),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rd        (dec_rd),
    .imm       (dec_imm),
    .alu_op    (dec_alu_op),
    .br_type   (dec_br_type),
    .rd_wr_mem (dec_rd_wr_mem),
    .wb_sel    (dec_wb_sel),
    .reg_wr    (dec_reg_wr),
    .mem_wr    (dec_mem_wr),
    .sel_a     (dec_sel_a),
    .sel_b     (dec_sel_b),
    .illegal   (dec_illegal),
    .rs1_used  (dec_rs1_used),
    .rs2_used  (dec_rs2_used)
  );

  // Load-use hazard: the load in EX writes a register this instruction actually reads.
  assign hazard = ex_load && (ex_rd != 5'd0) &&
                  ((dec_rs1_used && (dec_rs1 == ex_rd)) ||
                   (dec_rs2_used && (dec_rs2 == ex_rd)));

  // The slot can take new contents when it is empty or EX is draining it.
  assign advance  = !id_valid || ex_ready;
  assign id_ready = !rst && !hazard && advance && !flush;

  // Pipeline register: reset clears, flush kills, otherwise load on advance or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_rs1       <= '0;
      id_rs2       <= '0;
      id_rd        <= '0;
      id_imm       <= '0;
      id_alu_op    <= '0;
      id_br_type   <= '0;
      id_rd_wr_mem <= '0;
      id_wb_sel    <= '0;
      id_reg_wr    <= 1'b0;
      id_mem_wr    <= 1'b0;
      id_sel_A     <= 1'b0;
      id_sel_B     <= 1'b0;
      id_illegal   <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (advance) begin
      id_valid     <= if_valid && !hazard;
      id_pc        <= if_pc;
      id_rs1       <= dec_rs1;
      id_rs2       <= dec_rs2;
      id_rd        <= dec_rd;
      id_imm       <= dec_imm;
      id_alu_op    <= dec_alu_op;
      id_br_type   <= dec_br_type;
      id_rd_wr_mem <= dec_rd_wr_mem;
      id_wb_sel    <= dec_wb_sel;
      id_reg_wr    <= dec_reg_wr;
      id_mem_wr    <= dec_mem_wr;
      id_sel_A     <= dec_sel_a;
      id_sel_B     <= dec_sel_b;
      id_illegal   <= dec_illegal;
    end
  end

  // Saturating count of cycles where fetch offered a word that was refused (flush cycles excluded).
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (if_valid && !id_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
